// File: rtl/right_shift_iter_if.sv
// rtl/right_shift_iter_if.sv - request/result handshake bundle for right_shift_iter
// Optional i_arith signal is present only when RSHIFT_ARITH_EN is defined.
interface right_shift_iter_if #(
  parameter int width = 8
);
  localparam int SW = $clog2(width);

  logic             i_valid;
  logic             i_ready;
  logic [width-1:0] i_bits;
  logic [SW-1:0]    shift;
`ifdef RSHIFT_ARITH_EN
  logic             i_arith;
`endif
  logic             o_valid;
  logic             o_ready;
  logic [width-1:0] o_bits;

  modport master (
    output i_valid,
    output i_bits,
    output shift,
`ifdef RSHIFT_ARITH_EN
    output i_arith,
`endif
    output o_ready,
    input  i_ready,
    input  o_valid,
    input  o_bits
  );

  modport slave (
    input  i_valid,
    input  i_bits,
    input  shift,
`ifdef RSHIFT_ARITH_EN
    input  i_arith,
`endif
    input  o_ready,
    output i_ready,
    output o_valid,
    output o_bits
  );
endinterface

// File: rtl/right_shift_iter.sv
// rtl/right_shift_iter.sv - iterative log2 right shifter, one barrel stage per clock
// Define RSHIFT_ARITH_EN to add the i_arith (sign-fill) option.
module right_shift_iter #(
  parameter int width = 8
) (
  input  logic              clk,
  input  logic              rst,
  right_shift_iter_if.slave bus
);
  localparam int SW = $clog2(width);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [width-1:0] data;
  logic [width-1:0] res;
  logic [width-1:0] stage_out;
  logic [SW-1:0]    shamt;
  logic [SW-1:0]    k;
  logic [SW-1:0]    stage_amt;
  logic             last;
  logic             take;
  logic             stage_en;
`ifdef RSHIFT_ARITH_EN
  logic             arith_q;
  logic             sign_q;
  logic [width-1:0] fill;
`endif

  assign take      = (state == IDLE) && bus.i_valid;
  assign stage_amt = SW'(1) << k;
  assign last      = (k == SW'(SW - 1));
  assign stage_en  = shamt[k];

  // Every stage fills with the original MSB, so cumulative stages compose into one arithmetic shift.
`ifdef RSHIFT_ARITH_EN
  assign fill      = {width{arith_q & sign_q}};
  assign stage_out = (data >> stage_amt) | (fill & ~({width{1'b1}} >> stage_amt));
`else
  assign stage_out = data >> stage_amt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_valid) state_nxt = SHIFT;
      SHIFT:   if (last)        state_nxt = DONE;
      DONE:    if (bus.o_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.i_ready = 1'b0;
    bus.o_valid = 1'b0;
    case (state)
      IDLE:    bus.i_ready = 1'b1;
      DONE:    bus.o_valid = 1'b1;
      default: ;
    endcase
  end

  // res is loaded only on the final stage, so o_bits stays put through backpressure and idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      res     <= '0;
      shamt   <= '0;
      k       <= '0;
`ifdef RSHIFT_ARITH_EN
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
`endif
    end else if (take) begin
      data    <= bus.i_bits;
      shamt   <= bus.shift;
      k       <= '0;
`ifdef RSHIFT_ARITH_EN
      arith_q <= bus.i_arith;
      sign_q  <= bus.i_bits[width-1];
`endif
    end else if (state == SHIFT) begin
      if (stage_en) data <= stage_out;
      if (last)     res  <= stage_en ? stage_out : data;
      k <= k + SW'(1);
    end
  end

  assign bus.o_bits = res;
endmodule
